ecc32_encoder: RTL and testbench

//  Generates the 8 check bits for a 32-bit data word. The check bits form the companion codeword that the

---
 rtl/ecc32_pkg.sv | 21 ++
 rtl/ecc32_parity.sv | 18 +
 rtl/ecc32_encoder.sv | 120 ++++++++++++
 tb/tb_ecc32_encoder.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc32_pkg.sv
// ecc32_pkg: shared constants and types for the 32-bit check-bit encoder.
//   CHK_MASK   - even-parity masks, one per check bit
//   codeword_t - packed {chk, data}; bit n < 32 is data[n], bit 32+k is chk[k]
//   INJ_LIMIT  - first injection position that is ignored
package ecc32_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CHK_W     = 8;
    localparam int unsigned INJ_LIMIT = 40;

    localparam logic [DATA_W-1:0] CHK_MASK [CHK_W] = '{
        32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
        32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
    };

    typedef struct packed {
        logic [CHK_W-1:0]  chk;
        logic [DATA_W-1:0] data;
    } codeword_t;

endpackage

// File: rtl/ecc32_parity.sv
// ecc32_parity: purely combinational 32 -> 8 check-bit generator.
//   data_i [31:0]  data word
//   chk_o  [7:0]   chk[i] = even parity of (data & CHK_MASK[i])
module ecc32_parity
    import ecc32_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [CHK_W-1:0]  chk_o
);

    always_comb begin
        chk_o = '0;
        for (int unsigned i = 0; i < CHK_W; i++) begin
            chk_o[i] = ^(data_i & CHK_MASK[i]);
        end
    end

endmodule

// File: rtl/ecc32_encoder.sv
// ecc32_encoder: write-side ECC encoder, 2-stage valid/ready pipeline.
//   Gclk, Grst             clock, asynchronous active-high reset
//   in_valid/in_ready      input handshake, in_data [31:0]
//   out_valid/out_ready    output handshake, out_data [31:0], out_chk [7:0]
//   inj_valid, inj_pos     arm a single-bit flip (pos 0-31 data, 32-39 chk)
//   inj_armed              flip pending
//   word_cnt [CNT_W-1:0]   completed output handshakes, wrapping
module ecc32_encoder
    import ecc32_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             Gclk,
    input  logic             Grst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [7:0]       out_chk,
    input  logic             inj_valid,
    input  logic [5:0]       inj_pos,
    output logic             inj_armed,
    output logic [CNT_W-1:0] word_cnt
);

    logic              s1_v_q, s1_v_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic              s2_v_q, s2_v_d;
    codeword_t         s2_q, s2_d;
    logic              inj_armed_q, inj_armed_d;
    logic [5:0]        inj_pos_q, inj_pos_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              s1_take, s2_take, s1_move, inj_req;
    logic [CHK_W-1:0]  clean_chk;
    codeword_t         clean_cw, flip_mask;

    // Check bits always come from the unflipped S1 data.
    ecc32_parity u_parity (
        .data_i (s1_data_q),
        .chk_o  (clean_chk)
    );

    always_comb begin
        s2_take   = !s2_v_q || out_ready;
        s1_take   = !s1_v_q || s2_take;
        s1_move   = s1_v_q && s2_take;
        inj_req   = inj_valid && (32'(inj_pos) < INJ_LIMIT);
        clean_cw  = {clean_chk, s1_data_q};
        flip_mask = '0;
        if (inj_armed_q) begin
            flip_mask = codeword_t'(40'd1 << inj_pos_q);
        end

        s1_v_d      = s1_v_q;
        s1_data_d   = s1_data_q;
        s2_v_d      = s2_v_q;
        s2_d        = s2_q;
        inj_armed_d = inj_armed_q;
        inj_pos_d   = inj_pos_q;
        cnt_d       = cnt_q;

        if (s1_take) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
            end
        end

        if (s2_take) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_d = clean_cw ^ flip_mask;
            end
        end

        // A new request wins over the clear: the word moving this cycle
        // uses the old position, the new one waits for the next word.
        if (inj_req) begin
            inj_armed_d = 1'b1;
            inj_pos_d   = inj_pos;
        end else if (s1_move) begin
            inj_armed_d = 1'b0;
        end

        if (s2_v_q && out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Gclk or posedge Grst) begin
        if (Grst) begin
            s1_v_q      <= 1'b0;
            s1_data_q   <= '0;
            s2_v_q      <= 1'b0;
            s2_q        <= '0;
            inj_armed_q <= 1'b0;
            inj_pos_q   <= '0;
            cnt_q       <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_data_q   <= s1_data_d;
            s2_v_q      <= s2_v_d;
            s2_q        <= s2_d;
            inj_armed_q <= inj_armed_d;
            inj_pos_q   <= inj_pos_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = s1_take;
    assign out_valid = s2_v_q;
    assign out_data  = s2_q.data;
    assign out_chk   = s2_q.chk;
    assign inj_armed = inj_armed_q;
    assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_ecc32_encoder.sv
module tb_ecc32_encoder;

    localparam int unsigned CNT_W = 4;

    localparam logic [31:0] TB_MASK [8] = '{
        32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
        32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
    };

    logic             Gclk;
    logic             Grst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [7:0]       out_chk;
    logic             inj_valid;
    logic [5:0]       inj_pos;
    logic             inj_armed;
    logic [CNT_W-1:0] word_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    ecc32_encoder #(.CNT_W(CNT_W)) dut (
        .Gclk      (Gclk),
        .Grst      (Grst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chk   (out_chk),
        .inj_valid (inj_valid),
        .inj_pos   (inj_pos),
        .inj_armed (inj_armed),
        .word_cnt  (word_cnt)
    );

    initial Gclk = 1'b0;
    always #5 Gclk = ~Gclk;

    // Reference: parity counted bit-by-bit over each mask.
    function automatic logic [7:0] model_chk(input logic [31:0] d);
        logic [7:0] c;
        for (int i = 0; i < 8; i++) c[i] = ($countones(d & TB_MASK[i]) % 2) == 1;
        return c;
    endfunction

    // Reference single-error corrector: match the syndrome against each data column.
    function automatic logic [31:0] model_correct(input logic [31:0] d, input logic [7:0] c);
        logic [7:0]  syn;
        logic [7:0]  col;
        logic [31:0] r;
        syn = model_chk(d) ^ c;
        r   = d;
        if (syn != 8'h00) begin
            for (int n = 0; n < 32; n++) begin
                for (int i = 0; i < 8; i++) col[i] = TB_MASK[i][n];
                if (col == syn) r = d ^ (32'd1 << n);
            end
        end
        return r;
    endfunction

    task automatic next_neg();
        @(posedge Gclk);
        @(negedge Gclk);
    endtask

    task automatic do_reset();
        Grst = 1'b1;
        @(negedge Gclk);
        Grst = 1'b0;
        @(negedge Gclk);
    endtask

    task automatic arm(input logic [5:0] pos);
        inj_valid = 1'b1;
        inj_pos   = pos;
        next_neg();
        inj_valid = 1'b0;
    endtask

    // Send one word into an empty pipeline with no backpressure and observe it.
    task automatic send_one(input logic [31:0] data, output logic v_early, output logic v_out,
                            output logic [31:0] d_out, output logic [7:0] c_out,
                            output logic armed_after);
        in_valid  = 1'b1;
        in_data   = data;
        out_ready = 1'b1;
        next_neg();
        in_valid = 1'b0;
        v_early  = out_valid;
        next_neg();
        v_out       = out_valid;
        d_out       = out_data;
        c_out       = out_chk;
        armed_after = inj_armed;
        next_neg();
    endtask

    task automatic test_reset();
        Grst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        inj_valid = 1'b0; inj_pos = '0;
        repeat (2) @(negedge Gclk);
        Grst = 1'b0;
        @(negedge Gclk);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests_run++;
        if ({out_chk, out_data} !== 40'h0) begin tests_failed++; $display("FAIL reset_outputs: got %h expected 0", {out_chk, out_data}); end
        tests_run++;
        if (inj_armed !== 1'b0) begin tests_failed++; $display("FAIL reset_inj_armed: got %b expected 0", inj_armed); end
        tests_run++;
        if (word_cnt !== '0) begin tests_failed++; $display("FAIL reset_word_cnt: got %0d expected 0", word_cnt); end
    endtask

    task automatic test_single();
        logic [31:0] vec_d [5];
        logic [7:0]  vec_c [5];
        logic ve, vo, aa;
        logic [31:0] d;
        logic [7:0]  c;
        vec_d = '{32'h00000001, 32'h80000000, 32'h00010000, 32'hFFFFFFFF, 32'h00000000};
        vec_c = '{8'h51, 8'h8A, 8'h15, 8'h00, 8'h00};
        for (int k = 0; k < 5; k++) begin
            send_one(vec_d[k], ve, vo, d, c, aa);
            tests_run++;
            if (ve !== 1'b0 || vo !== 1'b1) begin
                tests_failed++; $display("FAIL single_latency[%0d]: got early=%b late=%b expected 0/1", k, ve, vo);
            end
            tests_run++;
            if (d !== vec_d[k] || c !== vec_c[k] || c !== model_chk(vec_d[k])) begin
                tests_failed++; $display("FAIL single_word[%0d]: got %h/%h expected %h/%h", k, c, d, vec_c[k], vec_d[k]);
            end
        end
        tests_run++;
        if (word_cnt !== 4'd5) begin tests_failed++; $display("FAIL single_word_cnt: got %0d expected 5", word_cnt); end
    endtask

    task automatic test_bubble();
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = a;
        next_neg();
        in_valid = 1'b0;
        next_neg();
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL bubble_accept: got valid=%b ready=%b expected 1/1", out_valid, in_ready);
        end
        in_valid = 1'b1; in_data = b;
        next_neg();
        in_valid = 1'b0;
        tests_run++;
        if (in_ready !== 1'b0 || out_data !== a) begin
            tests_failed++; $display("FAIL bubble_full: got ready=%b data=%h expected 0/%h", in_ready, out_data, a);
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bubble_comb_ready: got %b expected 1", in_ready); end
        next_neg();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== b || out_chk !== model_chk(b)) begin
            tests_failed++; $display("FAIL bubble_second: got %h/%h expected %h/%h", out_chk, out_data, model_chk(b), b);
        end
        next_neg();
    endtask

    task automatic test_burst();
        logic [31:0] words [64];
        int sent, rcvd, cyc;
        logic prev_hold, saw_low;
        logic [39:0] prev_cw;
        for (int k = 0; k < 64; k++) words[k] = $urandom;
        sent = 0; rcvd = 0; cyc = 0; prev_hold = 1'b0; saw_low = 1'b0; prev_cw = '0;
        while ((sent < 64 || rcvd < 64) && cyc < 600) begin
            if (cyc >= 6 && cyc < 9)  out_ready = 1'b0;
            else if (cyc >= 20)       out_ready = ($urandom_range(0, 3) != 0);
            else                      out_ready = 1'b1;
            in_valid = (sent < 64);
            in_data  = (sent < 64) ? words[sent] : 32'h0;
            #1;
            if (prev_hold) begin
                tests_run++;
                if ({out_chk, out_data} !== prev_cw || out_valid !== 1'b1) begin
                    tests_failed++; $display("FAIL burst_stall_stable: got %h expected %h", {out_chk, out_data}, prev_cw);
                end
            end
            if (cyc >= 6 && cyc < 9 && in_ready === 1'b0) saw_low = 1'b1;
            if (out_valid && out_ready) begin
                tests_run++;
                if (rcvd >= 64 || out_data !== words[rcvd] || out_chk !== model_chk(words[rcvd])) begin
                    tests_failed++;
                    $display("FAIL burst_word[%0d]: got %h/%h expected %h/%h", rcvd, out_chk, out_data,
                             model_chk(words[rcvd % 64]), words[rcvd % 64]);
                end
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
            prev_hold = out_valid && !out_ready;
            prev_cw   = {out_chk, out_data};
            next_neg();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tests_run++;
        if (rcvd != 64) begin tests_failed++; $display("FAIL burst_complete: got %0d words expected 64", rcvd); end
        tests_run++;
        if (saw_low !== 1'b1) begin tests_failed++; $display("FAIL burst_in_ready_low: got %b expected 1", saw_low); end
        repeat (2) next_neg();
    endtask

    task automatic test_injection();
        logic ve, vo, aa;
        logic [31:0] d, a, b;
        logic [7:0]  c;
        arm(6'd5);
        tests_run++;
        if (inj_armed !== 1'b1) begin tests_failed++; $display("FAIL inj_armed_set: got %b expected 1", inj_armed); end
        send_one(32'h0, ve, vo, d, c, aa);
        tests_run++;
        if (d !== 32'h20 || c !== 8'h00 || aa !== 1'b0) begin
            tests_failed++; $display("FAIL inj_pos5: got %h/%h armed=%b expected 00/00000020 armed=0", c, d, aa);
        end
        arm(6'd39);
        send_one(32'h1, ve, vo, d, c, aa);
        tests_run++;
        if (d !== 32'h1 || c !== 8'hD1) begin
            tests_failed++; $display("FAIL inj_pos39: got %h/%h expected d1/00000001", c, d);
        end
        arm(6'd45);
        tests_run++;
        if (inj_armed !== 1'b0) begin tests_failed++; $display("FAIL inj_pos45_armed: got %b expected 0", inj_armed); end
        a = $urandom;
        send_one(a, ve, vo, d, c, aa);
        tests_run++;
        if (d !== a || c !== model_chk(a)) begin
            tests_failed++; $display("FAIL inj_pos45_clean: got %h/%h expected %h/%h", c, d, model_chk(a), a);
        end
        // Request arriving on the transfer cycle applies to the following word.
        a = $urandom; b = $urandom;
        arm(6'd3);
        in_valid = 1'b1; in_data = a; out_ready = 1'b1;
        next_neg();
        in_valid = 1'b0; inj_valid = 1'b1; inj_pos = 6'd7;
        next_neg();
        inj_valid = 1'b0;
        tests_run++;
        if (out_data !== (a ^ 32'h8) || out_chk !== model_chk(a) || inj_armed !== 1'b1) begin
            tests_failed++; $display("FAIL inj_coincide_first: got %h/%h armed=%b expected %h/%h armed=1",
                                     out_chk, out_data, inj_armed, model_chk(a), a ^ 32'h8);
        end
        next_neg();
        send_one(b, ve, vo, d, c, aa);
        tests_run++;
        if (d !== (b ^ 32'h80) || c !== model_chk(b) || aa !== 1'b0) begin
            tests_failed++; $display("FAIL inj_coincide_second: got %h/%h armed=%b expected %h/%h armed=0",
                                     c, d, aa, model_chk(b), b ^ 32'h80);
        end
    endtask

    task automatic test_loopback();
        logic ve, vo, aa;
        logic [31:0] d, w;
        logic [7:0]  c;
        int bad;
        bad = 0;
        for (int p = 0; p < 32; p++) begin
            w = $urandom;
            arm(6'(p));
            send_one(w, ve, vo, d, c, aa);
            tests_run++;
            if (d !== (w ^ (32'd1 << p)) || model_correct(d, c) !== w) begin
                tests_failed++; bad++;
                $display("FAIL loopback_inj[%0d]: got corrected %h raw %h expected %h", p, model_correct(d, c), d, w);
            end
        end
        for (int k = 0; k < 8; k++) begin
            w = $urandom;
            send_one(w, ve, vo, d, c, aa);
            tests_run++;
            if (d !== w || model_correct(d, c) !== w) begin
                tests_failed++; $display("FAIL loopback_clean[%0d]: got %h expected %h", k, model_correct(d, c), w);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic ve, vo, aa;
        logic [31:0] d;
        logic [7:0]  c;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = $urandom;
        next_neg();
        in_data = $urandom;
        next_neg();
        in_valid = 1'b0;
        arm(6'd12);
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || inj_armed !== 1'b1) begin
            tests_failed++; $display("FAIL midrst_precond: got valid=%b ready=%b armed=%b expected 1/0/1",
                                     out_valid, in_ready, inj_armed);
        end
        #2 Grst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || inj_armed !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL midrst_async: got valid=%b armed=%b ready=%b expected 0/0/1",
                                     out_valid, inj_armed, in_ready);
        end
        tests_run++;
        if (word_cnt !== '0 || {out_chk, out_data} !== 40'h0) begin
            tests_failed++; $display("FAIL midrst_regs: got cnt=%0d cw=%h expected 0/0", word_cnt, {out_chk, out_data});
        end
        #1 Grst = 1'b0;
        @(negedge Gclk);
        send_one(32'h12345678, ve, vo, d, c, aa);
        tests_run++;
        if (vo !== 1'b1 || d !== 32'h12345678 || c !== model_chk(32'h12345678)) begin
            tests_failed++; $display("FAIL midrst_first_clean: got %h/%h expected %h/12345678", c, d, model_chk(32'h12345678));
        end
    endtask

    task automatic test_cnt_wrap();
        int sent, rcvd, cyc;
        logic [31:0] words [17];
        for (int k = 0; k < 17; k++) words[k] = $urandom;
        do_reset();
        sent = 0; rcvd = 0; cyc = 0;
        out_ready = 1'b1;
        while (rcvd < 17 && cyc < 100) begin
            in_valid = (sent < 17);
            in_data  = (sent < 17) ? words[sent] : 32'h0;
            #1;
            if (out_valid && out_ready) begin
                tests_run++;
                if (rcvd >= 17 || out_data !== words[rcvd]) begin
                    tests_failed++; $display("FAIL wrap_word[%0d]: got %h expected %h", rcvd, out_data, words[rcvd % 17]);
                end
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
            next_neg();
            cyc++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (rcvd != 17 || word_cnt !== 4'd1) begin
            tests_failed++; $display("FAIL wrap_word_cnt: got cnt=%0d words=%0d expected 1/17", word_cnt, rcvd);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bubble();
        test_burst();
        test_injection();
        test_loopback();
        test_reset_midflight();
        test_cnt_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
